// File: rtl/lcd_scanline_fx.sv
// Scanline darkening stage placed after the LCD video generator.
// Two pce-cycle pipeline; frame-stable mode and a line-group cadence pick the darkened lines.
module lcd_scanline_fx #(
  parameter int GROUP_LOG2 = 2,
  parameter int LCNT_W     = 10
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       pce,
  input  logic [1:0] sl_mode,
  input  logic       sl_alt,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       blank_in,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic       hs_out,
  output logic       vs_out,
  output logic       de_out,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out
);

  localparam logic [GROUP_LOG2-1:0] PH_LAST = '1;

  logic [LCNT_W-1:0]     line_cnt;
  logic                  frame_odd;
  logic [1:0]            mode_q;
  logic                  alt_q;
  logic                  vs_d;
  logic                  de_d;
  logic [GROUP_LOG2-1:0] phase;
  logic                  dark;
  logic                  vs_rise;
  logic                  act_fall;

  // Stage-1 pipeline registers; mode_s1 carries the attenuation (0 = pass through)
  logic       hs_s1, vs_s1, de_s1;
  logic [1:0] mode_s1;
  logic [7:0] r_s1, g_s1, b_s1;

  function automatic logic [7:0] atten(input logic [1:0] m, input logic [7:0] x);
    case (m)
      2'd1:    return x - {2'b00, x[7:2]};
      2'd2:    return {1'b0, x[7:1]};
      2'd3:    return {2'b00, x[7:2]};
      default: return x;
    endcase
  endfunction

  always_comb begin
    phase    = line_cnt[GROUP_LOG2-1:0];
    dark     = (mode_q != 2'd0) &&
               ((alt_q && frame_odd) ? (phase == '0) : (phase == PH_LAST));
    vs_rise  = vs_in && !vs_d;
    act_fall = de_d && blank_in;
  end

  // Frame/line bookkeeping; a vs rise overrides a coincident end-of-line
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt  <= '0;
      frame_odd <= 1'b0;
      mode_q    <= 2'd0;
      alt_q     <= 1'b0;
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
    end else if (pce) begin
      vs_d <= vs_in;
      de_d <= !blank_in;
      if (vs_rise) begin
        line_cnt  <= '0;
        frame_odd <= !frame_odd;
        mode_q    <= sl_mode;
        alt_q     <= sl_alt;
      end else if (act_fall) begin
        line_cnt <= line_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1   <= 1'b0;
      vs_s1   <= 1'b0;
      de_s1   <= 1'b0;
      mode_s1 <= 2'd0;
      r_s1    <= 8'h00;
      g_s1    <= 8'h00;
      b_s1    <= 8'h00;
    end else if (pce) begin
      hs_s1   <= hs_in;
      vs_s1   <= vs_in;
      de_s1   <= !blank_in;
      mode_s1 <= dark ? mode_q : 2'd0;
      r_s1    <= r_in;
      g_s1    <= g_in;
      b_s1    <= b_in;
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      de_out <= 1'b0;
      r_out  <= 8'h00;
      g_out  <= 8'h00;
      b_out  <= 8'h00;
    end else if (pce) begin
      hs_out <= hs_s1;
      vs_out <= vs_s1;
      de_out <= de_s1;
      r_out  <= de_s1 ? atten(mode_s1, r_s1) : 8'h00;
      g_out  <= de_s1 ? atten(mode_s1, g_s1) : 8'h00;
      b_out  <= de_s1 ? atten(mode_s1, b_s1) : 8'h00;
    end
  end

endmodule

// File: tb/tb_lcd_scanline_fx.sv
// Directed bench for lcd_scanline_fx: a reference model pushes expected pixels into a
// scoreboard queue as stimulus is applied; outputs are popped and compared after each edge.
module tb_lcd_scanline_fx;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } px_t;

  logic       pclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pce = 1'b1;
  logic [1:0] sl_mode = 2'd0;
  logic       sl_alt = 1'b0;
  logic       hs_in = 1'b0, vs_in = 1'b0, blank_in = 1'b0;
  logic [7:0] r_in = 8'h00, g_in = 8'h00, b_in = 8'h00;
  logic       hs_out, vs_out, de_out;
  logic [7:0] r_out, g_out, b_out;

  int  vectors = 0;
  int  miscompares = 0;
  px_t q[$];
  px_t last_exp;
  logic [7:0] last_r;
  bit  stretch = 0;

  int  m_line;
  bit  m_odd, m_alt, m_vsd, m_ded;
  int  m_mode;

  lcd_scanline_fx #(.GROUP_LOG2(2), .LCNT_W(10)) dut (
    .pclk(pclk), .reset_n(reset_n), .pce(pce),
    .sl_mode(sl_mode), .sl_alt(sl_alt),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  always #5 pclk = ~pclk;

  function automatic logic [7:0] att(input int m, input logic [7:0] x);
    int v;
    case (m)
      1:       v = int'(x) - int'(x) / 4;
      2:       v = int'(x) / 2;
      3:       v = int'(x) / 4;
      default: v = int'(x);
    endcase
    return v[7:0];
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(output px_t e);
    int  ph;
    bit  dk;
    ph = m_line % 4;
    dk = (m_mode != 0) && ((m_alt && m_odd) ? (ph == 0) : (ph == 3));
    e.hs = hs_in;
    e.vs = vs_in;
    e.de = !blank_in;
    e.r  = blank_in ? 8'h00 : (dk ? att(m_mode, r_in) : r_in);
    e.g  = blank_in ? 8'h00 : (dk ? att(m_mode, g_in) : g_in);
    e.b  = blank_in ? 8'h00 : (dk ? att(m_mode, b_in) : b_in);
    if (vs_in && !m_vsd) begin
      m_line = 0;
      m_odd  = !m_odd;
      m_mode = int'(sl_mode);
      m_alt  = sl_alt;
    end else if (m_ded && blank_in) begin
      m_line = (m_line + 1) % 1024;
    end
    m_vsd = vs_in;
    m_ded = !blank_in;
  endtask

  task automatic cyc(input logic p);
    px_t e, got;
    pce = p;
    @(posedge pclk);
    if (p) begin
      model_step(e);
      q.push_back(e);
    end
    #1;
    if (p && q.size() >= 2) last_exp = q.pop_front();
    got = {hs_out, vs_out, de_out, r_out, g_out, b_out};
    vectors++;
    assert (got === last_exp) else begin
      miscompares++;
      $error("FAIL pix observed=%h expected=%h", got, last_exp);
    end
    if (de_out) last_r = r_out;
  endtask

  task automatic px(input logic hs, input logic vs, input logic bl, input logic [7:0] c);
    hs_in = hs; vs_in = vs; blank_in = bl;
    r_in = c; g_in = c; b_in = c;
    cyc(1'b1);
    if (stretch) cyc(1'b0);
  endtask

  task automatic line(input int npix, input logic [7:0] c, input int nhb);
    for (int i = 0; i < npix; i++) px(1'b0, 1'b0, 1'b0, c);
    for (int i = 0; i < nhb; i++) px(i == 0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic vsync();
    px(1'b0, 1'b1, 1'b1, 8'h00);
    px(1'b0, 1'b1, 1'b1, 8'h00);
    px(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line(6, 8'hFF, 2);
  endtask

  logic [7:0] cad [8];
  logic [7:0] exp_ff [4];
  logic [7:0] exp_03 [4];
  int dark_cnt;

  initial begin
    cad = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    exp_ff = '{8'hFF, 8'hC0, 8'h7F, 8'h3F};
    exp_03 = '{8'h03, 8'h03, 8'h01, 8'h00};

    // reset holds outputs at zero despite active inputs
    r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("reset_out", int'({hs_out, vs_out, de_out, r_out, g_out, b_out}), 0);
    end
    reset_n = 1'b1;
    m_line = 0; m_odd = 0; m_mode = 0; m_alt = 0; m_vsd = 0; m_ded = 0;
    last_exp = '0;
    q.push_back('0);

    // latency: 0xA5 appears after the second pce edge
    px(1'b0, 1'b0, 1'b0, 8'hA5);
    chk("lat_r1", int'(r_out), 0);
    chk("lat_de1", int'(de_out), 0);
    px(1'b0, 1'b0, 1'b0, 8'hA5);
    chk("lat_r2", int'(r_out), 8'hA5);
    chk("lat_de2", int'(de_out), 1);
    px(1'b0, 1'b0, 1'b1, 8'h00);
    px(1'b0, 1'b0, 1'b1, 8'h00);

    // cadence, then the same with pce stretched
    sl_mode = 2'd2;
    for (int s = 0; s < 2; s++) begin
      stretch = (s == 1);
      vsync();
      for (int k = 0; k < 8; k++) begin
        line(6, 8'hFF, 2);
        chk($sformatf("cad_s%0d_l%0d", s, k), int'(last_r), int'(cad[k]));
      end
    end
    stretch = 0;

    // arithmetic on dark line 3 for each mode
    for (int m = 1; m < 4; m++) begin
      sl_mode = m[1:0];
      vsync();
      lines(3);
      line(6, 8'hFF, 2);
      chk($sformatf("arith_ff_m%0d", m), int'(last_r), int'(exp_ff[m]));
      lines(3);
      line(6, 8'h03, 2);
      chk($sformatf("arith_03_m%0d", m), int'(last_r), int'(exp_03[m]));
    end

    // mid-frame mode change waits for the next vs rise
    sl_mode = 2'd2;
    vsync();
    lines(2);
    sl_mode = 2'd0;
    line(6, 8'hFF, 2);
    line(6, 8'hFF, 2);
    chk("midframe_still_dark", int'(last_r), 8'h7F);
    vsync();
    lines(3);
    line(6, 8'hFF, 2);
    chk("midframe_off", int'(last_r), 8'hFF);

    // phase alternation over two frames
    sl_mode = 2'd2; sl_alt = 1'b1;
    for (int f = 0; f < 2; f++) begin
      vsync();
      for (int k = 0; k < 8; k++) begin
        line(6, 8'hFF, 2);
        chk($sformatf("alt_f%0d_l%0d", f, k), int'(last_r),
            (m_odd ? (k % 4 == 0) : (k % 4 == 3)) ? 8'h7F : 8'hFF);
      end
    end
    sl_alt = 1'b0;

    // blanked pixels on a dark line are forced to zero
    vsync();
    lines(3);
    line(6, 8'hFF, 0);
    px(1'b0, 1'b0, 1'b1, 8'hFF);
    px(1'b0, 1'b0, 1'b1, 8'hFF);
    chk("blank_r", int'(r_out), 0);
    chk("blank_de", int'(de_out), 0);

    // vs rise on the same pce as an active fall
    vsync();
    lines(2);
    line(6, 8'hFF, 0);
    vsync();
    line(6, 8'hFF, 2);
    chk("coinc_l0", int'(last_r), 8'hFF);
    lines(2);
    line(6, 8'hFF, 2);
    chk("coinc_l3", int'(last_r), 8'h7F);

    // full 576-line frame: one dark line per group of four
    vsync();
    dark_cnt = 0;
    for (int k = 0; k < 576; k++) begin
      line(8, 8'hFF, 2);
      if (last_r == 8'h7F) dark_cnt++;
    end
    vsync();
    chk("frame_dark_lines", dark_cnt, 144);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
